baud_gen: RTL and testbench

BAUD_GEN -- requirements
Module: baud_gen

---
 rtl/baud_pkg.sv | 13 +
 rtl/baud_tick_cnt.sv | 28 ++
 rtl/baud_gen.sv | 85 ++++++++
 tb/tb_baud_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// Shared types and constants for the baud-rate generator.
package baud_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DIV_W              = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

endpackage

// File: rtl/baud_tick_cnt.sv
// Divisor down-counter: counts D..0, reloads D after reaching zero.
module baud_tick_cnt
  import baud_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             zero
);

  logic [DIV_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div;
    end else if (en) begin
      cnt <= zero ? div : cnt - DIV_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/baud_gen.sv
// Baud-rate generator: rx_en every D+1 clocks, tx_en every OVERSAMPLE rx_en ticks,
// restarted by each rising edge of buf_rdy.
module baud_gen
  import baud_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_buf,
  input  logic             buf_rdy,
  output logic             rx_en,
  output logic             tx_en,
  output logic             running
);

  localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  state_t           state, state_nxt;
  logic             buf_rdy_q;
  logic             rdy_rise;
  logic [DIV_W-1:0] div_q;
  logic [OS_W-1:0]  os_cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_en;

  assign rdy_rise = buf_rdy & ~buf_rdy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      buf_rdy_q <= 1'b0;
      div_q     <= '0;
      os_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      buf_rdy_q <= buf_rdy;
      if (rdy_rise) begin
        div_q <= div_buf;
      end
      if (state == LOAD) begin
        os_cnt <= '0;
      end else if (rx_en) begin
        os_cnt <= os_cnt + OS_W'(1);
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: ;
      LOAD: begin
        cnt_load  = 1'b1;
        state_nxt = RUN;
      end
      RUN:     cnt_en = 1'b1;
      default: state_nxt = IDLE;
    endcase
    // A new edge wins over everything; a tick due this cycle is still emitted.
    if (rdy_rise) begin
      state_nxt = LOAD;
    end
  end

  baud_tick_cnt u_tick_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .div  (div_q),
    .zero (cnt_zero)
  );

  always_comb begin
    running = (state == RUN);
    rx_en   = running && cnt_zero;
    tx_en   = rx_en && (os_cnt == OS_W'(OVERSAMPLE - 1));
  end

endmodule

// File: tb/tb_baud_gen.sv
// Self-checking bench for baud_gen: directed scenarios plus random buf_rdy
// activity, checked every cycle against an arithmetic timing model.
module tb_baud_gen;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div_buf;
  logic        buf_rdy;
  logic        rx_en;
  logic        tx_en;
  logic        running;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: time of the last buf_rdy rising edge and its divisor.
  longint cyc;
  longint n_edge;
  longint d_ref;
  bit     active;
  bit     prev_rdy;
  logic   last_rx, last_tx;

  baud_gen #(.OVERSAMPLE(OS)) dut (
    .clk     (clk),
    .rst     (rst),
    .div_buf (div_buf),
    .buf_rdy (buf_rdy),
    .rx_en   (rx_en),
    .tx_en   (tx_en),
    .running (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s @cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, compare, advance the model.
  task automatic step();
    logic   e_rx, e_tx, e_run;
    longint off, k;
    @(negedge clk);
    e_rx  = 1'b0;
    e_tx  = 1'b0;
    e_run = 1'b0;
    if (active && cyc >= n_edge + 2) begin
      e_run = 1'b1;
      off   = cyc - n_edge - 2;
      if (off >= d_ref && ((off - d_ref) % (d_ref + 1)) == 0) begin
        e_rx = 1'b1;
        k    = (off - d_ref) / (d_ref + 1);
        e_tx = ((k % OS) == OS - 1);
      end
    end
    check("rx_en", rx_en, e_rx);
    check("tx_en", tx_en, e_tx);
    check("running", running, e_run);
    last_rx = rx_en;
    last_tx = tx_en;
    if (buf_rdy && !prev_rdy) begin
      active = 1'b1;
      n_edge = cyc;
      d_ref  = longint'(div_buf);
    end
    prev_rdy = buf_rdy;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Called at posedge+1; pulses rst mid-cycle and releases it at posedge+1.
  task automatic do_reset(input logic rdy_at_release, input logic [15:0] d);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rx", rx_en, 1'b0);
    check("async_rst_tx", tx_en, 1'b0);
    check("async_rst_running", running, 1'b0);
    buf_rdy = rdy_at_release;
    div_buf = d;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("in_rst_running", running, 1'b0);
    rst      = 1'b0;
    active   = 1'b0;
    prev_rdy = 1'b0;
  endtask

  initial begin
    int rx_cnt, tx_cnt, coinc;
    rst      = 1'b1;
    buf_rdy  = 1'b0;
    div_buf  = '0;
    cyc      = 0;
    n_edge   = 0;
    d_ref    = 0;
    active   = 1'b0;
    prev_rdy = 1'b0;
    @(posedge clk);
    #1;
    check("reset_rx", rx_en, 1'b0);
    check("reset_tx", tx_en, 1'b0);
    check("reset_running", running, 1'b0);
    rst = 1'b0;

    // Idle with no edge, then D=3: rx every 4 clocks from N+5, first tx at N+65.
    run(5);
    div_buf = 16'd3;
    buf_rdy = 1'b1;
    run(140);

    // D=0: rx every RUN cycle, tx every 16.
    buf_rdy = 1'b0;
    run(3);
    div_buf = 16'd0;
    buf_rdy = 1'b1;
    run(40);

    // D=10, buf_rdy drops (no effect), then rises with D=2.
    buf_rdy = 1'b0;
    run(2);
    div_buf = 16'd10;
    buf_rdy = 1'b1;
    run(30);
    buf_rdy = 1'b0;
    div_buf = 16'd99;
    run(15);
    div_buf = 16'd2;
    buf_rdy = 1'b1;
    run(20);

    // Edge coinciding with an rx tick (D=2: rx at N+4).
    buf_rdy = 1'b0;
    run(2);
    buf_rdy = 1'b1;
    run(3);
    buf_rdy = 1'b0;
    div_buf = 16'd4;
    run(1);
    buf_rdy = 1'b1;
    run(25);

    // Reset mid-period with D=5, then quiet until a fresh edge.
    buf_rdy = 1'b0;
    run(1);
    div_buf = 16'd5;
    buf_rdy = 1'b1;
    run(9);
    do_reset(1'b0, 16'd5);
    run(20);

    // buf_rdy high through reset release with D=1.
    do_reset(1'b1, 16'd1);
    run(20);

    // D=7 over 16*(D+1)*4 clocks: 64 rx, 4 tx, each tx on an rx.
    buf_rdy = 1'b0;
    run(2);
    div_buf = 16'd7;
    buf_rdy = 1'b1;
    run(2);
    rx_cnt = 0;
    tx_cnt = 0;
    coinc  = 0;
    for (int i = 0; i < 16 * 8 * 4; i++) begin
      step();
      if (last_rx === 1'b1) rx_cnt++;
      if (last_tx === 1'b1) tx_cnt++;
      if (last_tx === 1'b1 && last_rx === 1'b1) coinc++;
    end
    check_int("rx_count_d7", rx_cnt, 64);
    check_int("tx_count_d7", tx_cnt, 4);
    check_int("tx_on_rx_d7", coinc, 4);

    // Random buf_rdy toggling, divisor changes, and one random reset.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 14) == 0) begin
        buf_rdy = ~buf_rdy;
        if (buf_rdy) div_buf = 16'($urandom_range(0, 6));
      end else if ($urandom_range(0, 9) == 0) begin
        div_buf = 16'($urandom_range(0, 6));
      end
      if (i == 400) do_reset(1'($urandom_range(0, 1)), 16'($urandom_range(0, 6)));
      step();
    end

    // Largest divisor: first rx exactly N+2+65535, no overflow.
    buf_rdy = 1'b0;
    run(2);
    div_buf = 16'hFFFF;
    buf_rdy = 1'b1;
    run(65545);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
